// File: rtl/branch_history_ctrl_pkg.sv
// Shared constants and types for the gshare global-history controller.
package branch_history_ctrl_pkg;
  localparam int PC_WIDTH        = 32;
  localparam int PC_ALIGN        = 2;
  localparam int GHR_WIDTH_DEF   = 8;
  localparam int QUEUE_DEPTH_DEF = 4;

  // Outcome of the resolve port on a given edge
  typedef enum logic [1:0] {
    RES_IDLE = 2'd0,
    RES_HIT  = 2'd1,
    RES_MISS = 2'd2
  } res_kind_e;
endpackage

// File: rtl/branch_history_ctrl_if.sv
// Prediction/resolve/training bundle between fetch, decode and the history controller.
interface branch_history_ctrl_if #(
  parameter int GHR_WIDTH = 8
);
  import branch_history_ctrl_pkg::*;

  logic                 pred_valid;
  logic [PC_WIDTH-1:0]  pred_pc;
  logic                 pred_taken;
  logic                 pred_ready;
  logic [GHR_WIDTH-1:0] index;
  logic                 res_valid;
  logic                 res_taken;
  logic                 flush;
  logic                 is_last_branch;
  logic                 is_last_taken;
  logic [GHR_WIDTH-1:0] last_index;
  logic                 mispredict;

  modport master (
    output pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
    input  pred_ready, index, is_last_branch, is_last_taken, last_index, mispredict
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
    output pred_ready, index, is_last_branch, is_last_taken, last_index, mispredict
  );
endinterface

// File: rtl/branch_history_ctrl_fifo.sv
// history_fifo: ring buffer of in-flight predictions; clear wins over push, pop still advances head.
module history_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail, head_nxt;
  logic [PW:0]      cnt;
  logic             push_ok, pop_ok;

  assign full      = (cnt == (PW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && !full && !clear;
  assign head_nxt  = head + PW'(pop_ok);
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_nxt;
      if (clear) begin
        // collapse onto the post-pop head so the next push lands at the new head
        tail <= head_nxt;
        cnt  <= '0;
      end else begin
        tail <= tail + PW'(push_ok);
        cnt  <= cnt + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end
endmodule

// File: rtl/branch_history_ctrl.sv
// gshare history owner: index hash, in-flight prediction queue, training outputs, GHR repair.
module branch_history_ctrl
  import branch_history_ctrl_pkg::*;
#(
  parameter int GHR_WIDTH   = GHR_WIDTH_DEF,
  parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
  input logic                    clk,
  input logic                    rst,
  branch_history_ctrl_if.slave   bh
);
  localparam int EW = GHR_WIDTH + 1;

  logic [GHR_WIDTH-1:0] ghr_spec, ghr_commit, ghr_commit_nxt;
  logic [GHR_WIDTH-1:0] idx;
  logic [EW-1:0]        head_data;
  logic                 q_full, q_empty;
  logic                 push, clear;
  res_kind_e            res_kind;

  logic                 lb_q, lt_q, mp_q;
  logic [GHR_WIDTH-1:0] li_q;
  logic                 unused_pc;

  assign unused_pc = ^{bh.pred_pc[PC_WIDTH-1:GHR_WIDTH+PC_ALIGN], bh.pred_pc[PC_ALIGN-1:0]};

  assign idx           = bh.pred_pc[GHR_WIDTH+PC_ALIGN-1:PC_ALIGN] ^ ghr_spec;
  assign bh.index      = idx;
  assign bh.pred_ready = !q_full;

  always_comb begin
    res_kind = RES_IDLE;
    if (bh.res_valid && !q_empty)
      res_kind = (bh.res_taken != head_data[0]) ? RES_MISS : RES_HIT;
  end

  assign ghr_commit_nxt = (res_kind != RES_IDLE) ? {ghr_commit[GHR_WIDTH-2:0], bh.res_taken}
                                                 : ghr_commit;
  assign clear = (res_kind == RES_MISS) || bh.flush;
  assign push  = bh.pred_valid && !q_full && !clear;

  history_fifo #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({idx, bh.pred_taken}),
    .pop       (res_kind != RES_IDLE),
    .clear     (clear),
    .full      (q_full),
    .empty     (q_empty),
    .head_data (head_data)
  );

  // On a mispredict the post-update commit history already ends in the actual outcome
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_spec   <= '0;
      ghr_commit <= '0;
    end else begin
      ghr_commit <= ghr_commit_nxt;
      if (clear)     ghr_spec <= ghr_commit_nxt;
      else if (push) ghr_spec <= {ghr_spec[GHR_WIDTH-2:0], bh.pred_taken};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lb_q <= 1'b0;
      lt_q <= 1'b0;
      li_q <= '0;
      mp_q <= 1'b0;
    end else begin
      lb_q <= (res_kind != RES_IDLE);
      if (res_kind != RES_IDLE) begin
        lt_q <= bh.res_taken;
        li_q <= head_data[EW-1:1];
        mp_q <= (res_kind == RES_MISS);
      end
    end
  end

  assign bh.is_last_branch = lb_q;
  assign bh.is_last_taken  = lt_q;
  assign bh.last_index     = li_q;
  assign bh.mispredict     = mp_q;
endmodule

// File: tb/tb_branch_history_ctrl.sv
// Directed + randomized check of branch_history_ctrl against a queue-based reference model.
module tb_branch_history_ctrl;
  localparam int W = 8;
  localparam int D = 4;

  logic clk, rst;
  int   n_chk, n_fail;

  branch_history_ctrl_if #(.GHR_WIDTH(W)) bh();

  branch_history_ctrl #(.GHR_WIDTH(W), .QUEUE_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bh  (bh)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: history as plain integers, queue of {index, predicted}
  logic [W-1:0] m_spec, m_commit, m_li;
  logic         m_lb, m_lt, m_mp;
  logic [W:0]   m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic pv, input logic [31:0] pc, input logic pt,
                     input logic rv, input logic rt, input logic fl);
    logic [W-1:0] eidx;
    logic         rdy, mp;
    logic [W:0]   e;
    rst = r; bh.pred_valid = pv; bh.pred_pc = pc; bh.pred_taken = pt;
    bh.res_valid = rv; bh.res_taken = rt; bh.flush = fl;
    #1;
    eidx = pc[W+1:2] ^ m_spec;
    rdy  = (m_q.size() < D);
    chk("index", bh.index, eidx);
    chk("pred_ready", bh.pred_ready, rdy);
    if (!r) begin
      m_spec = '0; m_commit = '0; m_q.delete();
      m_lb = 0; m_lt = 0; m_li = '0; m_mp = 0;
    end else begin
      mp = 1'b0;
      m_lb = 1'b0;
      if (rv && m_q.size() > 0) begin
        e = m_q.pop_front();
        mp = (rt != e[0]);
        m_commit = {m_commit[W-2:0], rt};
        m_lb = 1'b1; m_lt = rt; m_li = e[W:1]; m_mp = mp;
      end
      if (mp || fl) begin
        m_q.delete();
        m_spec = m_commit;
      end else if (pv && rdy) begin
        m_q.push_back({eidx, pt});
        m_spec = {m_spec[W-2:0], pt};
      end
    end
    @(posedge clk);
    #1;
    chk("is_last_branch", bh.is_last_branch, m_lb);
    chk("is_last_taken", bh.is_last_taken, m_lt);
    chk("last_index", bh.last_index, m_li);
    chk("mispredict", bh.mispredict, m_mp);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic pt);
    cyc(1, 1, pc, pt, 0, 0, 0);
  endtask

  task automatic peek(input string tag, input logic [31:0] pc, input logic [W-1:0] exp_idx,
                      input logic exp_rdy);
    bh.pred_valid = 0; bh.res_valid = 0; bh.flush = 0; bh.pred_pc = pc;
    #1;
    chk({tag, "_index"}, bh.index, exp_idx);
    chk({tag, "_ready"}, bh.pred_ready, exp_rdy);
  endtask

  initial begin
    logic       r, pv, pt, rv, rt, fl;
    logic [31:0] pc;
    n_chk = 0; n_fail = 0;
    rst = 0; bh.pred_valid = 0; bh.pred_pc = '0; bh.pred_taken = 0;
    bh.res_valid = 0; bh.res_taken = 0; bh.flush = 0;
    m_spec = '0; m_commit = '0; m_lb = 0; m_lt = 0; m_li = '0; m_mp = 0;
    @(posedge clk); #1;

    // reset state
    do_reset();
    peek("rst", 32'h10, 8'h04, 1'b1);
    chk("rst_lb", bh.is_last_branch, 1'b0);

    // history shift T,N,T -> ghr_spec 0x05
    push(32'h10, 1); push(32'h10, 0); push(32'h10, 1);
    peek("shift", 32'h10, 8'h01, 1'b1);

    // correct resolve, then flush exposes ghr_commit through the index
    do_reset();
    push(32'h10, 1);
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("res_lb", bh.is_last_branch, 1'b1);
    chk("res_li", bh.last_index, 8'h04);
    chk("res_lt", bh.is_last_taken, 1'b1);
    chk("res_mp", bh.mispredict, 1'b0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    peek("commit", 32'h0, 8'h01, 1'b1);

    // mispredict with a same-cycle wrong-path push
    do_reset();
    push(32'h0, 1); push(32'h0, 0); push(32'h0, 0);
    cyc(1, 1, 32'h40, 1, 1, 0, 0);
    chk("mp_flag", bh.mispredict, 1'b1);
    peek("mp", 32'h0, 8'h00, 1'b1);
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("mp_empty", bh.is_last_branch, 1'b0);

    // full queue backpressure
    do_reset();
    for (int i = 0; i < D; i++) push(32'h0, 1);
    peek("full", 32'h0, 8'h0f, 1'b0);
    push(32'h0, 1);
    peek("full5", 32'h0, 8'h0f, 1'b0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    peek("drain", 32'h0, 8'h0f, 1'b1);

    // flush with simultaneous correct not-taken resolve
    do_reset();
    push(32'h0, 0); push(32'h0, 0);
    cyc(1, 0, 0, 0, 1, 0, 1);
    chk("fl_lb", bh.is_last_branch, 1'b1);
    chk("fl_mp", bh.mispredict, 1'b0);
    peek("fl", 32'h0, 8'h00, 1'b1);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("fl_nopulse", bh.is_last_branch, 1'b0);

    // randomized traffic, resolves biased toward correct predictions
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) != 0);
      pv = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      pt = $urandom_range(0, 1);
      rv = ($urandom_range(0, 2) == 0);
      rt = $urandom_range(0, 1);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) rt = m_q[0][0];
      fl = ($urandom_range(0, 39) == 0);
      cyc(r, pv, pc, pt, rv, rt, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_history_ctrl.md
# branch_history_ctrl

Owns the global history state for the gshare predictor. In the PC stage it hashes the fetch PC with the speculative GHR to produce the counter-table lookup index. It remembers each in-flight prediction in a small queue. When ID resolves a branch, it emits the registered update triple (`is_last_branch`, `is_last_taken`, `last_index`) that trains the counter table, and it repairs the speculative history on a mispredict or flush.

## Interface
- `GHR_WIDTH`, default 8: history and index width; equals log2 of `PHT_SIZE`.
- `QUEUE_DEPTH`, default 4: in-flight prediction entries; must be a power of two, at least 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `pred_valid` in 1: PC stage presents a branch prediction this cycle.
- `pred_pc` in 32: fetch PC of the predicted branch.
- `pred_taken` in 1: direction returned by the counter table for `index`.
- `pred_ready` out 1: queue not full; a prediction is accepted when `pred_valid && pred_ready`.
- `index` out GHR_WIDTH: lookup index, `pred_pc[GHR_WIDTH+1:2] ^ ghr_spec`.
- `res_valid` in 1: ID resolves the oldest in-flight branch. Branches resolve strictly in program order.
- `res_taken` in 1: actual direction of that branch.
- `flush` in 1: pipeline flush (exception/eret); discards all in-flight predictions.
- `is_last_branch` out 1: training pulse to the counter table.
- `is_last_taken` out 1: actual direction being trained.
- `last_index` out GHR_WIDTH: index that was used when the branch was predicted.
- `mispredict` out 1: resolved direction differed from the stored prediction; valid with `is_last_branch`.

## Operation
- State:
  - `ghr_spec`: speculative history.
  - `ghr_commit`: architectural history.
  - Ring buffer of `{index, pred_taken}` with head/tail pointers and a count of width log2(QUEUE_DEPTH)+1.
- Push (accepted prediction): write `{index, pred_taken}` at tail, then tail+1 with wrap. Update `ghr_spec <= {ghr_spec[GHR_WIDTH-2:0], pred_taken}`.
- Resolve (`res_valid` and queue non-empty):
  - Pop head.
  - Update `ghr_commit <= {ghr_commit[GHR_WIDTH-2:0], res_taken}`.
  - Register the outputs `is_last_branch=1`, `is_last_taken=res_taken`, `last_index=head.index`, `mispredict=(res_taken != head.pred_taken)`.
- Mispredict repair, same edge as the resolve:
  - Clear the queue: count 0, tail=head.
  - Set `ghr_spec <= {ghr_commit[GHR_WIDTH-2:0], res_taken}`.
  - Drop any push in that cycle (wrong path).
- `res_valid` with empty queue: ignored. No pop, no GHR change, no output pulse.
- `flush`:
  - Clear the queue and drop the push in that cycle.
  - Set `ghr_spec <=` the post-update `ghr_commit`. If a resolve occurs in the same cycle it is processed first, and its training pulse is still emitted.
- Push and non-mispredicting pop in the same cycle: both take effect; count unchanged.
- Full queue: `pred_ready=0` (computed from the current count, no same-cycle pop bypass). A `pred_valid` while full is not recorded and does not shift `ghr_spec`.
- Priority per edge: reset > resolve > flush/mispredict clear > push.

## Timing
- `index` and `pred_ready` are combinational from the current state and `pred_pc`, valid in the same cycle.
- Training outputs are registered. They appear one cycle after the `res_valid` edge, as a single-cycle pulse.
  - `is_last_taken`, `last_index` and `mispredict` hold their last values otherwise.
  - They are meaningful only while `is_last_branch=1`.
- The `ghr_spec` used by `index` reflects pushes and repairs from the previous edge only.
- Reset values: `ghr_spec=0`, `ghr_commit=0`, queue empty, `pred_ready=1`, `is_last_branch=0`, `is_last_taken=0`, `last_index=0`, `mispredict=0`.
- Reset mid-operation discards all entries on that edge. No training pulse is emitted for them.

## Structure
- `GHR_WIDTH`/`PHT_SIZE` and the gshare hash macro live in `branch.v`. Bus widths live in `bus.v`.
- One sub-module, `history_fifo`: a parameterised ring buffer with push, pop, clear, full, empty and head data. The controller holds both GHRs, the hash and the output registers.

## Test plan
- Reset: hold `rst=0` for 2 cycles, release, drive `pred_pc=0x00000010` → `index=0x04`, `pred_ready=1`, `is_last_branch=0`.
- History shift: push taken/not-taken/taken at `pred_pc=0x00000010` → `ghr_spec=0x05`, next `index=0x01`.
- Correct resolve: push (`index` 0x04, taken), then `res_valid=1`, `res_taken=1` → next cycle `is_last_branch=1`, `last_index=0x04`, `is_last_taken=1`, `mispredict=0`, and `ghr_commit=0x01`.
- Mispredict: 3 entries queued with `ghr_commit=0`, head predicted taken, resolve not-taken with a push in the same cycle → `mispredict=1`, queue empty, `ghr_spec=0x00`, and the pushed entry is absent.
- Full/backpressure: 4 pushes → `pred_ready=0`; a 5th `pred_valid` leaves `ghr_spec` unchanged. One resolve → `pred_ready=1` on the next cycle.
- Flush with simultaneous resolve (not-taken, correct) on a 2-entry queue → training pulse emitted, queue empty, `ghr_spec=ghr_commit=0x00`. `res_valid` on the empty queue afterwards → no pulse.
